// File: rtl/ad5676_spi_responder.sv
// ad5676_spi_responder
// Emulates the responder end of the AD5676 8-channel DAC serial link in the
// clk domain. It oversamples n_cs, sck and mosi, decodes 24-bit frames into the
// input and DAC registers, applies ldac, and exposes the DAC codes.
// Optional readback: define AD5676_SPI_RESPONDER_READBACK_EN.
module ad5676_spi_responder #(
   parameter logic [15:0] RESET_CODE  = 16'h8000,
   parameter int          SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         n_cs,
   input  logic         sck,
   input  logic         mosi,
   input  logic         ldac,
   output logic         miso,
   output logic [127:0] dac_val_concat,
   output logic         frame_done,
   output logic         bad_cmd,
   output logic         frame_len_err
);

   logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
   logic                   cs_prev_q, sck_prev_q;
   logic                   cs_s, sck_s, mosi_s;
   logic                   cs_fall, cs_rise, sck_fall;

   logic                   active_q;
   logic [23:0]            shift_q;
   logic [4:0]             bit_cnt_q;
   logic                   pend_q;
   logic [23:0]            frame_q;

   logic [7:0][15:0]       input_q, input_d;
   logic [7:0][15:0]       dac_q, dac_d;
   logic [7:0]             mask_q, mask_d;
   logic                   bad_d;
   logic [127:0]           dac_out_q;
   logic                   frame_done_q, bad_cmd_q, frame_len_err_q;

   logic [3:0]             cmd;
   logic [3:0]             addr;
   logic [15:0]            data;
   logic [2:0]             ch;

   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // n_cs chain resets low so a chip select still asserted across reset never
   // looks like a fresh falling edge; a frame only starts from a seen fall.
   assign cs_fall  = cs_prev_q & ~cs_s;
   assign cs_rise  = ~cs_prev_q & cs_s;
   assign sck_fall = sck_prev_q & ~sck_s & ~cs_s & active_q;

   assign cmd  = frame_q[23:20];
   assign addr = frame_q[19:16];
   assign data = frame_q[15:0];
   assign ch   = addr[2:0];

   // Input synchronizers and edge-detect history.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cs_sync_q   <= '0;
         sck_sync_q  <= '1;
         mosi_sync_q <= '0;
         cs_prev_q   <= 1'b0;
         sck_prev_q  <= 1'b1;
      end else begin
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], n_cs};
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         cs_prev_q   <= cs_s;
         sck_prev_q  <= sck_s;
      end
   end

   // Frame capture: shift on sck fall, qualify length on n_cs rise.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         active_q        <= 1'b0;
         shift_q         <= '0;
         bit_cnt_q       <= '0;
         pend_q          <= 1'b0;
         frame_q         <= '0;
         frame_len_err_q <= 1'b0;
      end else begin
         pend_q <= 1'b0;
         if (cs_fall) begin
            active_q  <= 1'b1;
            shift_q   <= '0;
            bit_cnt_q <= '0;
         end else if (cs_rise) begin
            active_q <= 1'b0;
            if (active_q) begin
               if (bit_cnt_q == 5'd24) begin
                  pend_q  <= 1'b1;
                  frame_q <= shift_q;
               end else begin
                  frame_len_err_q <= 1'b1;
               end
            end
         end else if (sck_fall) begin
            shift_q <= {shift_q[22:0], mosi_s};
            if (bit_cnt_q != 5'd31) begin
               bit_cnt_q <= bit_cnt_q + 5'd1;
            end
         end
      end
   end

`ifdef AD5676_SPI_RESPONDER_READBACK_EN
   logic        rb_sel;
   logic        sck_rise;
   logic [2:0]  rb_ch_q;
   logic        rb_pend_q, rb_active_q;
   logic [23:0] rb_shift_q;

   assign sck_rise = ~sck_prev_q & sck_s & ~cs_s;
`endif

   // Command decode and ldac; frame writes to a channel override ldac for it,
   // and a soft reset overrides everything.
   always_comb begin
      input_d = input_q;
      dac_d   = dac_q;
      mask_d  = mask_q;
      bad_d   = 1'b0;
`ifdef AD5676_SPI_RESPONDER_READBACK_EN
      rb_sel  = 1'b0;
`endif
      for (int i = 0; i < 8; i++) begin
         if (ldac && !mask_q[i]) begin
            dac_d[i] = input_q[i];
         end
      end
      if (pend_q) begin
         if (cmd == 4'b0101) begin
            mask_d = data[7:0];
         end else if (addr[3]) begin
            bad_d = 1'b1;
         end else begin
            case (cmd)
               4'b0000: ;
               4'b0001: input_d[ch] = data;
               4'b0010: dac_d[ch] = input_q[ch];
               4'b0011: begin
                  input_d[ch] = data;
                  dac_d[ch]   = data;
               end
               4'b0110: begin
                  if (data == 16'h1234) begin
                     input_d = {8{RESET_CODE}};
                     dac_d   = {8{RESET_CODE}};
                     mask_d  = '0;
                  end
               end
`ifdef AD5676_SPI_RESPONDER_READBACK_EN
               4'b1001: rb_sel = 1'b1;
`endif
               default: bad_d = 1'b1;
            endcase
         end
      end
   end

   // Register file, output copy and sticky flags.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         input_q      <= {8{RESET_CODE}};
         dac_q        <= {8{RESET_CODE}};
         mask_q       <= '0;
         dac_out_q    <= {8{RESET_CODE}};
         frame_done_q <= 1'b0;
         bad_cmd_q    <= 1'b0;
      end else begin
         input_q      <= input_d;
         dac_q        <= dac_d;
         mask_q       <= mask_d;
         dac_out_q    <= dac_q;
         frame_done_q <= pend_q;
         bad_cmd_q    <= bad_cmd_q | bad_d;
      end
   end

`ifdef AD5676_SPI_RESPONDER_READBACK_EN
   // Readback: arm on C=1001, load on the next n_cs fall, shift on sck rise.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rb_ch_q     <= '0;
         rb_pend_q   <= 1'b0;
         rb_active_q <= 1'b0;
         rb_shift_q  <= '0;
      end else begin
         if (rb_sel) begin
            rb_ch_q   <= ch;
            rb_pend_q <= 1'b1;
         end else if (cs_fall) begin
            if (rb_pend_q) begin
               rb_shift_q  <= {8'h00, input_q[rb_ch_q]};
               rb_active_q <= 1'b1;
               rb_pend_q   <= 1'b0;
            end
         end else if (cs_rise) begin
            if (rb_active_q) begin
               rb_active_q <= 1'b0;
               rb_ch_q     <= '0;
            end
         end else if (sck_rise && rb_active_q) begin
            rb_shift_q <= {rb_shift_q[22:0], 1'b0};
         end
      end
   end

   assign miso = rb_active_q & ~cs_s & rb_shift_q[23];
`else
   assign miso = 1'b0;
`endif

   assign dac_val_concat = dac_out_q;
   assign frame_done     = frame_done_q;
   assign bad_cmd        = bad_cmd_q;
   assign frame_len_err  = frame_len_err_q;

endmodule

// File: tb/tb_ad5676_spi_responder.sv
// Directed bench for ad5676_spi_responder: frames push an expected
// {channel, code, bad_cmd} entry; a monitor pops on each frame_done.
module tb_ad5676_spi_responder;

   logic         clk = 1'b0;
   logic         resetn, n_cs, sck, mosi, ldac;
   logic         miso;
   logic [127:0] dac_val_concat;
   logic         frame_done, bad_cmd, frame_len_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [2:0]  ch;
      logic [15:0] val;
      logic        bad;
   } exp_t;
   exp_t exp_q[$];

   ad5676_spi_responder #(.RESET_CODE(16'h8000), .SYNC_STAGES(2)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .n_cs           (n_cs),
      .sck            (sck),
      .mosi           (mosi),
      .ldac           (ldac),
      .miso           (miso),
      .dac_val_concat (dac_val_concat),
      .frame_done     (frame_done),
      .bad_cmd        (bad_cmd),
      .frame_len_err  (frame_len_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] field(input logic [2:0] c);
      return dac_val_concat[c*16 +: 16];
   endfunction

   task automatic shift_bits(input logic [31:0] d, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         mosi = d[i];
         repeat (2) @(negedge clk);
         sck = 1'b0;
         repeat (4) @(negedge clk);
         sck = 1'b1;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic send(input logic [31:0] d, input int n);
      n_cs = 1'b0;
      repeat (4) @(negedge clk);
      shift_bits(d, n);
      repeat (4) @(negedge clk);
      n_cs = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic frame(input logic [23:0] d, input logic [2:0] c, input logic [15:0] v, input logic b);
      exp_t e;
      e.ch = c; e.val = v; e.bad = b;
      exp_q.push_back(e);
      send({8'h00, d}, 24);
   endtask

   task automatic ldac_pulse;
      ldac = 1'b1;
      @(negedge clk);
      ldac = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // Scoreboard monitor: one expected entry per frame_done pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (frame_done === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_frame_done: got pulse want none");
            end else begin
               e = exp_q.pop_front();
               @(negedge clk);
               chk("frame_done_width", {127'd0, frame_done}, 128'd0);
               chk($sformatf("dac_ch%0d", e.ch), {112'd0, field(e.ch)}, {112'd0, e.val});
               chk("bad_cmd_after_frame", {127'd0, bad_cmd}, {127'd0, e.bad});
            end
         end
      end
   end

   initial begin
      resetn = 1'b0; n_cs = 1'b1; sck = 1'b1; mosi = 1'b0; ldac = 1'b0;
      repeat (5) @(negedge clk);
      resetn = 1'b1;
      repeat (6) @(negedge clk);
      chk("reset_concat", dac_val_concat, {8{16'h8000}});
      chk("reset_flags", {125'd0, frame_done, bad_cmd, frame_len_err}, 128'd0);
      chk("reset_miso", {127'd0, miso}, 128'd0);

      frame(24'h31ABCD, 3'd1, 16'hABCD, 1'b0);
      chk("write_update_others", dac_val_concat,
          {16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'hABCD, 16'h8000});

      frame(24'h171234, 3'd7, 16'h8000, 1'b0);
      chk("ch7_before_ldac", {112'd0, field(3'd7)}, {112'd0, 16'h8000});
      ldac_pulse();
      chk("ch7_after_ldac", {112'd0, field(3'd7)}, {112'd0, 16'h1234});

      frame(24'h500004, 3'd2, 16'h8000, 1'b0);
      frame(24'h120F0F, 3'd2, 16'h8000, 1'b0);
      frame(24'h1300FF, 3'd3, 16'h8000, 1'b0);
      ldac_pulse();
      chk("mask_ldac_ch3", {112'd0, field(3'd3)}, {112'd0, 16'h00FF});
      chk("mask_ldac_ch2", {112'd0, field(3'd2)}, {112'd0, 16'h8000});

      frame(24'h220000, 3'd2, 16'h0F0F, 1'b0);

      send(32'h0031_5555, 23);
      send(32'h0062_5555, 25);
      chk("len_err_flag", {126'd0, frame_len_err, bad_cmd}, {126'd0, 2'b10});
      chk("len_err_no_change", dac_val_concat,
          {16'h1234, 16'h8000, 16'h8000, 16'h8000, 16'h00FF, 16'h0F0F, 16'hABCD, 16'h8000});

      frame(24'h710000, 3'd1, 16'hABCD, 1'b1);
      frame(24'h920000, 3'd2, 16'h0F0F, 1'b1);
      frame(24'h600000, 3'd1, 16'hABCD, 1'b1);
      frame(24'h601234, 3'd1, 16'h8000, 1'b1);
      chk("soft_reset_concat", dac_val_concat, {8{16'h8000}});
      chk("soft_reset_flags_kept", {126'd0, frame_len_err, bad_cmd}, {126'd0, 2'b11});

      ldac = 1'b1;
      frame(24'h155555, 3'd0, 16'h8000, 1'b1);
      chk("held_ldac_ch5", {112'd0, field(3'd5)}, {112'd0, 16'h5555});
      ldac = 1'b0;
      chk("miso_tied_low", {127'd0, miso}, 128'd0);

      n_cs = 1'b0;
      repeat (4) @(negedge clk);
      shift_bits(32'h0000_0031, 12);
      resetn = 1'b0;
      repeat (4) @(negedge clk);
      resetn = 1'b1;
      shift_bits(32'h0000_0ABC, 12);
      repeat (4) @(negedge clk);
      n_cs = 1'b1;
      repeat (10) @(negedge clk);
      chk("midframe_reset_flags", {125'd0, frame_done, bad_cmd, frame_len_err}, 128'd0);
      chk("midframe_reset_concat", dac_val_concat, {8{16'h8000}});

      frame(24'h304321, 3'd0, 16'h4321, 1'b0);

      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL pending_frames: got %0d outstanding want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
